// File: rtl/rom_playback_ctrl.sv
// rtl/rom_playback_ctrl.sv - tone ROM to audio CODEC playback sequencer
// Optional PLAYBACK_VOLUME_EN adds vol_shift (arithmetic right shift of each sample).
module rom_playback_ctrl #(
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 24,
    parameter int DEPTH   = 48000,
    parameter int ROM_LAT = 2
) (
    input  logic              CLOCK_50,
    input  logic              reset,
    input  logic              start,
    input  logic              stop,
    input  logic              loop,
    input  logic              write_ready,
`ifdef PLAYBACK_VOLUME_EN
    input  logic [2:0]        vol_shift,
`endif
    input  logic [DATA_W-1:0] rom_q,
    output logic [ADDR_W-1:0] rom_addr,
    output logic              write,
    output logic [DATA_W-1:0] writedata_left,
    output logic [DATA_W-1:0] writedata_right,
    output logic              busy,
    output logic              done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2,
        WRITE = 2'd3
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
    localparam logic [2:0]        LAT_C     = 3'(ROM_LAT);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [2:0]        cnt_q, cnt_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              write_q, write_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [DATA_W-1:0] sample_cap;

`ifdef PLAYBACK_VOLUME_EN
    assign sample_cap = DATA_W'($signed(rom_q) >>> vol_shift);
`else
    assign sample_cap = rom_q;
`endif

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_q <= IDLE;
            addr_q  <= '0;
            cnt_q   <= '0;
            data_q  <= '0;
            write_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            write_q <= write_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // The first fetch after IDLE starts its count at 0 (one extra pipeline
    // fill cycle); fetches that follow a write start at 1, so the steady-state
    // period is ROM_LAT+2 cycles.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        write_d = 1'b0;
        done_d  = 1'b0;
        if (stop) begin
            state_d = IDLE;
            addr_d  = '0;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        state_d = FETCH;
                        addr_d  = '0;
                        cnt_d   = '0;
                    end
                end
                FETCH: begin
                    if (cnt_q == LAT_C) begin
                        data_d  = sample_cap;
                        state_d = HOLD;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 3'd1;
                    end
                end
                HOLD: begin
                    if (write_ready) begin
                        state_d = WRITE;
                        write_d = 1'b1;
                    end
                end
                WRITE: begin
                    if (addr_q != LAST_ADDR) begin
                        addr_d  = addr_q + 1'b1;
                        state_d = FETCH;
                        cnt_d   = 3'd1;
                    end else if (loop) begin
                        addr_d  = '0;
                        state_d = FETCH;
                        cnt_d   = 3'd1;
                    end else begin
                        addr_d  = '0;
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
        busy_d = (state_d != IDLE);
    end

    assign rom_addr        = addr_q;
    assign write           = write_q;
    assign writedata_left  = data_q;
    assign writedata_right = data_q;
    assign busy            = busy_q;
    assign done            = done_q;

endmodule

// File: tb/tb_rom_playback_ctrl.sv
// tb/tb_rom_playback_ctrl.sv - scoreboard bench for rom_playback_ctrl
module tb_rom_playback_ctrl;

    localparam int ADDR_W = 16;
    localparam int DATA_W = 24;
    localparam int DEPTH  = 4;
    localparam int LAT    = 2;

    logic              clk = 1'b0;
    logic              rst, start, stop, loop, write_ready;
    logic [2:0]        vol_shift;
    logic [DATA_W-1:0] rom_q;
    logic [ADDR_W-1:0] rom_addr;
    logic              write, busy, done;
    logic [DATA_W-1:0] wl, wr;

    rom_playback_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .ROM_LAT(LAT)) dut (
        .CLOCK_50       (clk),
        .reset          (rst),
        .start          (start),
        .stop           (stop),
        .loop           (loop),
        .write_ready    (write_ready),
`ifdef PLAYBACK_VOLUME_EN
        .vol_shift      (vol_shift),
`endif
        .rom_q          (rom_q),
        .rom_addr       (rom_addr),
        .write          (write),
        .writedata_left (wl),
        .writedata_right(wr),
        .busy           (busy),
        .done           (done)
    );

    always #5 clk = ~clk;

    // Registered address (DUT) plus one registered output stage = ROM_LAT 2.
    logic [DATA_W-1:0] mem [0:DEPTH-1];
    always @(posedge clk) rom_q <= mem[rom_addr[1:0]];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit                is_done;
        logic [DATA_W-1:0] data;
        logic [ADDR_W-1:0] addr;
    } exp_t;

    exp_t expq[$];
    int   wcyc[$];
    int   nw = 0;
    int   done_cyc = 0;
    int   applied = 0;
    int   errs = 0;
    logic prev_w = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        applied++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic push_w(input logic [DATA_W-1:0] d, input logic [ADDR_W-1:0] a);
        exp_t e;
        e.is_done = 1'b0; e.data = d; e.addr = a;
        expq.push_back(e);
    endtask

    task automatic push_done();
        exp_t e;
        e.is_done = 1'b1; e.data = '0; e.addr = '0;
        expq.push_back(e);
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (write) begin
                nw++;
                wcyc.push_back(cyc);
                chk("write_not_consecutive", {31'd0, prev_w}, 32'd0);
                chk("wr_eq_wl", wr, wl);
                if (expq.size() == 0 || expq[0].is_done) begin
                    chk("unexpected_write", 32'd1, 32'd0);
                end else begin
                    chk("write_data", wl, expq[0].data);
                    chk("write_addr", rom_addr, expq[0].addr);
                    void'(expq.pop_front());
                end
            end
            if (done) begin
                done_cyc = cyc;
                if (expq.size() == 0 || !expq[0].is_done) begin
                    chk("unexpected_done", 32'd1, 32'd0);
                end else begin
                    chk("done_pulse", {31'd0, done}, 32'd1);
                    void'(expq.pop_front());
                end
            end
        end
        prev_w = write;
    end

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_writes(input int n, input string nm);
        int k = 0;
        while (nw < n && k < 200) begin
            tick();
            k++;
        end
        chk(nm, {31'd0, (nw >= n)}, 32'd1);
    endtask

    initial begin
        int c0;
        for (int i = 0; i < DEPTH; i++) mem[i] = 24'h100000 + 24'(i);
        rst = 1'b1; start = 1'b0; stop = 1'b0; loop = 1'b0;
        write_ready = 1'b1; vol_shift = 3'd0;
        tick(2);
        rst = 1'b0;

        for (int i = 0; i < 20; i++) begin
            tick();
            chk("reset_idle", {rom_addr, 4'd0, write, busy, done, (wl == 0 && wr == 0)}, 32'h1);
        end

        // One-shot clip with no backpressure
        for (int i = 0; i < DEPTH; i++) push_w(24'h100000 + 24'(i), 16'(i));
        push_done();
        wcyc.delete(); nw = 0;
        c0 = cyc;
        pulse_start();
        wait_writes(4, "oneshot_writes");
        tick(3);
        chk("oneshot_first_latency", wcyc[0] - c0, 32'd5);
        for (int i = 1; i < 4; i++) chk("oneshot_period", wcyc[i] - wcyc[i-1], 32'd4);
        chk("oneshot_done_after_last", done_cyc - wcyc[3], 32'd1);
        chk("oneshot_busy_after", {31'd0, busy}, 32'd0);
        chk("oneshot_queue_empty", expq.size(), 32'd0);

        // Backpressure on sample 1, then stop during the fetch of sample 2
        push_w(24'h100000, 16'd0);
        push_w(24'h100001, 16'd1);
        nw = 0;
        pulse_start();
        wait_writes(1, "bp_first_write");
        write_ready = 1'b0;
        tick(2);
        for (int i = 0; i < 10; i++) begin
            chk("bp_no_write", {31'd0, write}, 32'd0);
            chk("bp_data_stable", wl, 32'h100001);
            tick();
        end
        write_ready = 1'b1;
        tick();
        chk("bp_release_write", {31'd0, write}, 32'd1);
        tick();
        chk("bp_addr_after", rom_addr, 32'd2);
        chk("bp_single_write", {31'd0, write}, 32'd0);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        chk("stop_idle", {29'd0, busy, write, done}, 32'd0);
        chk("stop_addr", rom_addr, 32'd0);
        chk("stop_data_held", wl, 32'h100001);
        tick(10);
        chk("stop_no_more_events", expq.size(), 32'd0);

        // Restart after stop begins again at sample 0
        for (int i = 0; i < DEPTH; i++) push_w(24'h100000 + 24'(i), 16'(i));
        push_done();
        nw = 0;
        pulse_start();
        wait_writes(4, "restart_writes");
        tick(3);
        chk("restart_queue_empty", expq.size(), 32'd0);
        chk("restart_busy_after", {31'd0, busy}, 32'd0);

        // Looping: seamless wrap with no done pulse
        loop = 1'b1;
        for (int i = 0; i < 6; i++) push_w(24'h100000 + 24'(i % DEPTH), 16'(i % DEPTH));
        wcyc.delete(); nw = 0;
        pulse_start();
        wait_writes(6, "loop_writes");
        stop = 1'b1;
        tick();
        stop = 1'b0;
        loop = 1'b0;
        for (int i = 1; i < 6; i++) chk("loop_period", wcyc[i] - wcyc[i-1], 32'd4);
        tick(10);
        chk("loop_queue_empty", expq.size(), 32'd0);
        chk("loop_stopped", {31'd0, busy}, 32'd0);

`ifdef PLAYBACK_VOLUME_EN
        mem[0] = 24'h800000;
        mem[1] = 24'h400000;
        push_w(24'hF00000, 16'd0);
        push_w(24'h100000, 16'd1);
        vol_shift = 3'd3;
        nw = 0;
        pulse_start();
        wait_writes(1, "vol_first");
        vol_shift = 3'd2;
        wait_writes(2, "vol_second");
        stop = 1'b1;
        tick();
        stop = 1'b0;
        tick(5);
        chk("vol_queue_empty", expq.size(), 32'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", applied, errs);
        $finish;
    end

endmodule
